seg_pair_decoder: RTL and testbench

- Receive-side counterpart of the two-digit seven-segment timer.
- Samples the two active-low segment buses that drive the digit pair, filters glitches, and decodes the patterns back to BCD tens/ones.
- Checks that successive values follow the timer's count sequence and flags violations.
- Sits on the board-level segment bus as an in-system monitor and self-check for timer/display logic.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_digit_decode.sv | 26 ++
 rtl/seg_pair_decoder.sv | 119 +++++++++++
 tb/tb_seg_pair_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment constants and monitor state type for the two-digit timer
// and its receive-side decoder.
package seg_pkg;

  localparam logic [7:0] SEG_CODE [0:9] = '{
    8'h02, 8'h9F, 8'h25, 8'h0D, 8'h99,
    8'h49, 8'h41, 8'h1F, 8'h01, 8'h09
  };
  localparam logic [7:0] SEG_BLANK      = 8'hFF;
  localparam logic [7:0] SEG_MATCH_MASK = 8'hFE;

  typedef enum logic {UNLOCKED, LOCKED} mon_state_e;

  function automatic logic [6:0] bcd_pair_val(input logic [3:0] tens, input logic [3:0] ones);
    logic [6:0] t7;
    logic [6:0] o7;
    t7 = {3'b000, tens};
    o7 = {3'b000, ones};
    return t7 * 7'd10 + o7;
  endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational decode of one active-low segment pattern to BCD; the dp bit
// takes no part in matching.
module seg_digit_decode
  import seg_pkg::*;
(
  input  logic [7:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] bcd
);

  always_comb begin
    legal = 1'b0;
    blank = 1'b0;
    bcd   = 4'h0;
    if ((seg & SEG_MATCH_MASK) == (SEG_BLANK & SEG_MATCH_MASK))
      blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if ((seg & SEG_MATCH_MASK) == (SEG_CODE[i] & SEG_MATCH_MASK)) begin
        legal = 1'b1;
        bcd   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_pair_decoder.sv
// In-system monitor for the two-digit seven-segment timer: filters the segment
// buses, decodes tens/ones and flags patterns that break the count sequence.
module seg_pair_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [7:0]       i_seg1,
  input  logic [7:0]       i_seg0,
  output logic [3:0]       o_tens,
  output logic [3:0]       o_ones,
  output logic             o_valid,
  output logic             o_invalid,
  output logic             o_step_err,
  output logic             o_locked,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam logic [7:0]  STABLE    = 8'(STABLE_CYCLES);
  localparam logic [15:0] PAIR_MASK = {SEG_MATCH_MASK, SEG_MATCH_MASK};

  function automatic logic [7:0] sat_stab(input logic [7:0] c);
    return (c >= STABLE) ? STABLE : c + 8'd1;
  endfunction

  function automatic logic [ERR_W-1:0] sat_err(input logic [ERR_W-1:0] e);
    return (&e) ? e : e + 1'b1;
  endfunction

  logic [15:0] pins_m;
  logic [15:0] samp_p0;
  logic [7:0]  stab_cnt_p0;
  logic [15:0] last_p1;
  mon_state_e  state_q, state_d;

  logic        legal1, blank1, legal0, blank0;
  logic [3:0]  bcd1, bcd0;
  logic        accept;
  logic        valid_d, invalid_d, step_d;
  logic [6:0]  prev_val, succ_val, new_val;

  assign pins_m = {i_seg1, i_seg0} & PAIR_MASK;

  // Stage 0: sample register and stability filter
  always_ff @(posedge clk) begin
    if (!reset) begin
      samp_p0     <= '0;
      stab_cnt_p0 <= '0;
    end else if (en) begin
      samp_p0     <= pins_m;
      stab_cnt_p0 <= (pins_m == samp_p0) ? sat_stab(stab_cnt_p0) : 8'd1;
    end else begin
      stab_cnt_p0 <= '0;
    end
  end

  seg_digit_decode u_dec_tens (.seg(samp_p0[15:8]), .legal(legal1), .blank(blank1), .bcd(bcd1));
  seg_digit_decode u_dec_ones (.seg(samp_p0[7:0]),  .legal(legal0), .blank(blank0), .bcd(bcd0));

  // last_p1 always holds a masked pattern, so a dp-only change is not a new value
  assign accept   = en && (stab_cnt_p0 == STABLE) && (samp_p0 != (last_p1 & PAIR_MASK));
  assign prev_val = bcd_pair_val(o_tens, o_ones);
  assign succ_val = (prev_val == 7'd99) ? 7'd0 : prev_val + 7'd1;
  assign new_val  = bcd_pair_val(bcd1, bcd0);

  always_comb begin
    state_d   = state_q;
    valid_d   = 1'b0;
    invalid_d = 1'b0;
    step_d    = 1'b0;
    if (accept) begin
      if (blank1 && blank0) begin
        state_d = UNLOCKED;
      end else if (!legal1 || !legal0) begin
        invalid_d = 1'b1;
        state_d   = UNLOCKED;
      end else begin
        valid_d = 1'b1;
        state_d = LOCKED;
        if (state_q == LOCKED && new_val != succ_val && new_val != 7'd0)
          step_d = 1'b1;
      end
    end
  end

  // Stage 1: accepted value, monitor state, pulses and error count
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= UNLOCKED;
      last_p1    <= 16'hFFFF;
      o_tens     <= '0;
      o_ones     <= '0;
      o_valid    <= 1'b0;
      o_invalid  <= 1'b0;
      o_step_err <= 1'b0;
      o_err_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      o_valid    <= valid_d;
      o_invalid  <= invalid_d;
      o_step_err <= step_d;
      if (accept)
        last_p1 <= samp_p0;
      if (valid_d) begin
        o_tens <= bcd1;
        o_ones <= bcd0;
      end
      if (invalid_d || step_d)
        o_err_cnt <= sat_err(o_err_cnt);
    end
  end

  assign o_locked = (state_q == LOCKED);

endmodule

// File: tb/tb_seg_pair_decoder.sv
// Directed bench for seg_pair_decoder: a reference model queues expected pulses
// as patterns are driven; a negedge monitor pops and compares them.
module tb_seg_pair_decoder;

  localparam int S = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b1;
  logic [7:0] seg1 = 8'hFF;
  logic [7:0] seg0 = 8'hFF;

  logic [3:0]  tens, ones, s_tens, s_ones;
  logic        valid, invalid, step_err, locked;
  logic        s_valid, s_invalid, s_step_err, s_locked;
  logic [15:0] err_cnt;
  logic [1:0]  s_err_cnt;

  seg_pair_decoder #(.STABLE_CYCLES(S), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .i_seg1(seg1), .i_seg0(seg0),
    .o_tens(tens), .o_ones(ones), .o_valid(valid), .o_invalid(invalid),
    .o_step_err(step_err), .o_locked(locked), .o_err_cnt(err_cnt)
  );

  seg_pair_decoder #(.STABLE_CYCLES(S), .ERR_W(2)) dut_s (
    .clk(clk), .reset(reset), .en(en), .i_seg1(seg1), .i_seg0(seg0),
    .o_tens(s_tens), .o_ones(s_ones), .o_valid(s_valid), .o_invalid(s_invalid),
    .o_step_err(s_step_err), .o_locked(s_locked), .o_err_cnt(s_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v, inv, se;
    logic [3:0] t, o;
    logic       lk;
    logic [15:0] e16;
    logic [1:0]  e2;
  } exp_t;

  exp_t q[$];
  logic [7:0] tab [0:9] = '{8'h02, 8'h9F, 8'h25, 8'h0D, 8'h99,
                            8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

  int total = 0, passed = 0;
  int n_valid = 0, n_se = 0;
  int base_v, base_se;

  logic [15:0] m_last;
  logic        m_lk;
  logic [3:0]  m_t, m_o;
  logic [15:0] m_e16;
  logic [1:0]  m_e2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int dec(input logic [7:0] s);
    if (s[7:1] == 7'h7F) return 10;
    for (int i = 0; i < 10; i++)
      if (tab[i][7:1] == s[7:1]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 16'hFEFE;
    m_lk = 1'b0;
    m_t = 4'd0;
    m_o = 4'd0;
    m_e16 = 16'd0;
    m_e2 = 2'd0;
    q.delete();
  endtask

  task automatic bump_err();
    if (m_e16 != 16'hFFFF) m_e16 = m_e16 + 16'd1;
    if (m_e2 != 2'd3) m_e2 = m_e2 + 2'd1;
  endtask

  task automatic predict(input logic [7:0] s1, input logic [7:0] s0);
    logic [15:0] p;
    int d1, d0, v, pv;
    exp_t e;
    p = {s1, s0} & 16'hFEFE;
    if (p == m_last) return;
    m_last = p;
    d1 = dec(s1);
    d0 = dec(s0);
    if (d1 == 10 && d0 == 10) begin
      m_lk = 1'b0;
      return;
    end
    e.v = 1'b0; e.inv = 1'b0; e.se = 1'b0;
    if (d1 < 0 || d0 < 0 || d1 == 10 || d0 == 10) begin
      m_lk = 1'b0;
      bump_err();
      e.inv = 1'b1;
    end else begin
      v  = d1 * 10 + d0;
      pv = int'(m_t) * 10 + int'(m_o);
      e.v = 1'b1;
      e.se = m_lk && (v != (pv + 1) % 100) && (v != 0);
      if (e.se) bump_err();
      m_t = 4'(d1);
      m_o = 4'(d0);
      m_lk = 1'b1;
    end
    e.t = m_t; e.o = m_o; e.lk = m_lk; e.e16 = m_e16; e.e2 = m_e2;
    q.push_back(e);
  endtask

  // Holds a pattern for n cycles, starting and ending just after a posedge
  task automatic drive(input logic [7:0] s1, input logic [7:0] s0, input int n);
    seg1 = s1;
    seg0 = s0;
    if (en && n > S) predict(s1, s0);
    repeat (n) @(posedge clk);
    #1;
    check("pending_expected", q.size(), 0);
    q.delete();
  endtask

  task automatic drive_val(input int v, input int n);
    drive(tab[v / 10], tab[v % 10], n);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && (valid || invalid || step_err)) begin
      if (valid) n_valid++;
      if (step_err) n_se++;
      check("invalid_step_exclusive", {31'd0, invalid & step_err}, 0);
      if (q.size() == 0) begin
        check("unexpected_pulse", {29'd0, valid, invalid, step_err}, 0);
      end else begin
        e = q.pop_front();
        check("pulses", {29'd0, valid, invalid, step_err}, {29'd0, e.v, e.inv, e.se});
        check("tens", tens, e.t);
        check("ones", ones, e.o);
        check("locked", locked, e.lk);
        check("err_cnt16", err_cnt, e.e16);
        check("pulses_w2", {29'd0, s_valid, s_invalid, s_step_err}, {29'd0, e.v, e.inv, e.se});
        check("err_cnt2", s_err_cnt, e.e2);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {tens, ones, valid, invalid, step_err, locked, err_cnt}, 0);
    check("rst_outputs_w2", {s_tens, s_ones, s_valid, s_invalid, s_step_err, s_locked, s_err_cnt}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // First pattern: 00, pulse five edges after it appears
    seg1 = tab[0];
    seg0 = tab[0];
    predict(tab[0], tab[0]);
    repeat (S) @(posedge clk);
    @(negedge clk);
    check("latency_early", valid, 1'b0);
    @(negedge clk);
    check("latency_valid", valid, 1'b1);
    check("first_locked", locked, 1'b1);
    check("first_err", err_cnt, 0);
    @(posedge clk);
    #1;
    q.delete();

    // Full count 01..99 then wrap to 00
    base_se = n_se;
    for (int i = 1; i <= 100; i++) drive_val(i % 100, 6);
    check("count_valids", n_valid, 101);
    check("count_step_errs", n_se, base_se);
    check("wrap_value", {tens, ones}, 8'h00);

    // 01..07 then 04: step error alongside valid
    for (int i = 1; i <= 7; i++) drive_val(i, 6);
    drive_val(4, 6);
    check("step_err_cnt", err_cnt, 1);
    check("step_ones", ones, 4);
    check("step_locked", locked, 1'b1);

    // 05..12 then illegal ones digit
    for (int i = 5; i <= 12; i++) drive_val(i, 6);
    drive(8'h9F, 8'hFF, 6);
    check("inv_locked", locked, 1'b0);
    check("inv_hold", {tens, ones}, 8'h12);
    check("inv_err_cnt", err_cnt, 2);
    drive_val(13, 6);
    check("relock", locked, 1'b1);
    check("relock_err", err_cnt, 2);

    // Short glitch, then the same glitch while disabled
    base_v = n_valid;
    drive(8'h9F, 8'h99, 3);
    drive_val(13, 6);
    en = 1'b0;
    drive(8'h9F, 8'h99, 10);
    drive_val(13, 3);
    en = 1'b1;
    drive_val(13, 6);
    check("glitch_no_valid", n_valid, base_v);
    check("glitch_err", err_cnt, 2);
    check("glitch_hold", {tens, ones}, 8'h13);

    // Both blank unlocks silently; next legal value relocks without step check
    drive(8'hFF, 8'hFF, 6);
    check("blank_locked", locked, 1'b0);
    check("blank_hold", {tens, ones}, 8'h13);
    drive_val(21, 6);
    check("blank_relock", locked, 1'b1);
    check("blank_err", err_cnt, 2);

    // Five step errors saturate the 2-bit counter
    base_se = n_se;
    drive_val(50, 6);
    drive_val(20, 6);
    drive_val(40, 6);
    drive_val(60, 6);
    drive_val(80, 6);
    check("five_step_errs", n_se, base_se + 5);
    check("err16_after", err_cnt, 7);
    check("err2_saturated", s_err_cnt, 2'd3);

    // dp-bit differences are ignored: 81 is a legal successor
    drive(tab[8] ^ 8'h01, tab[1] ^ 8'h01, 6);
    check("dp_value", {tens, ones}, 8'h81);
    check("dp_err", err_cnt, 7);

    // Reset while a new pattern is mid-filter
    drive_val(22, 2);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_outputs", {tens, ones, valid, invalid, step_err, locked, err_cnt}, 0);
    check("midrst_outputs_w2", {s_tens, s_ones, s_valid, s_invalid, s_step_err, s_locked, s_err_cnt}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    drive_val(22, 6);
    check("post_rst_value", {tens, ones}, 8'h22);
    check("post_rst_locked", locked, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
